encoder8_3_scan: RTL

- Sequential 8-to-3 encoder. It is the inverse of the team's 3-to-8 decoder.
- Captures an 8-bit request vector and emits the 3-bit index of every set bit, one per beat, highest index first.
- Uses a valid/ready handshake on both sides.
- Sits between request sources (keys, IRQ lines, decoder outputs under test) and a consumer that needs binary codes.

---
 rtl/enc_pkg.sv | 29 ++
 rtl/prio_enc8.sv | 20 ++
 rtl/encoder8_3_scan.sv | 129 ++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and bit helpers for the sequential 8-to-3 encoder.
package enc_pkg;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ZERO = 2'd2
  } state_t;

  // Drop the bit that was just emitted from the pending vector.
  function automatic logic [IN_W-1:0] clear_bit(input logic [IN_W-1:0] vec,
                                                input logic [OUT_W-1:0] idx);
    return vec & ~(IN_W'(1) << idx);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] vec);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < IN_W; i++) begin
      n = n + CNT_W'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational priority encoder: highest set index of an 8-bit vector plus an exactly-one-bit flag.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [IN_W-1:0]  vec,
  output logic [OUT_W-1:0] idx_c,
  output logic             single_c
);

  // Later (higher) indices overwrite earlier ones, leaving the highest set bit.
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) idx_c = OUT_W'(i);
    end
  end

  assign single_c = (vec != '0) && ((vec & (vec - IN_W'(1))) == '0);

endmodule

// File: rtl/encoder8_3_scan.sv
// Sequential 8-to-3 encoder: captures a request vector and emits one code per set bit, highest first.
// Optional popcount output count_out is enabled by defining ENC_COUNT_EN.
module encoder8_3_scan
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] code_out,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             code_last,
  output logic             code_zero
`ifdef ENC_COUNT_EN
  ,
  output logic [CNT_W-1:0] count_out
`endif
);

  state_t           state_q, state_d;
  logic [IN_W-1:0]  pend_q, pend_d;
  logic             capture_c;
  logic             accept_c;
  logic [OUT_W-1:0] nxt_idx_c;
  logic             nxt_single_c;

  logic             in_ready_d;
  logic             code_valid_d;
  logic [OUT_W-1:0] code_out_d;
  logic             code_last_d;
  logic             code_zero_d;

  assign capture_c = in_valid && in_ready && (state_q == IDLE);
  assign accept_c  = code_valid && code_ready;

  // Outputs are registered from the next pend value, so they come only from flops.
  prio_enc8 u_prio (
    .vec      (pend_d),
    .idx_c    (nxt_idx_c),
    .single_c (nxt_single_c)
  );

  // Next-state, next-pend and next-output logic.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    in_ready_d   = 1'b0;
    code_valid_d = 1'b0;
    code_out_d   = '0;
    code_last_d  = 1'b0;
    code_zero_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture_c) begin
          pend_d  = in_vec;
          state_d = (in_vec != '0) ? EMIT : ZERO;
        end
      end
      EMIT: begin
        if (accept_c) begin
          pend_d = clear_bit(pend_q, code_out);
          if (pend_d == '0) state_d = IDLE;
        end
      end
      ZERO: begin
        if (accept_c) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase

    case (state_d)
      IDLE: begin
        in_ready_d = 1'b1;
      end
      EMIT: begin
        code_valid_d = 1'b1;
        code_out_d   = nxt_idx_c;
        code_last_d  = nxt_single_c;
      end
      ZERO: begin
        code_valid_d = 1'b1;
        code_last_d  = 1'b1;
        code_zero_d  = 1'b1;
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

  // State, pend and output registers; reset discards any remaining beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      in_ready   <= 1'b0;
      code_valid <= 1'b0;
      code_out   <= '0;
      code_last  <= 1'b0;
      code_zero  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      in_ready   <= in_ready_d;
      code_valid <= code_valid_d;
      code_out   <= code_out_d;
      code_last  <= code_last_d;
      code_zero  <= code_zero_d;
    end
  end

`ifdef ENC_COUNT_EN
  // Popcount of the captured vector, held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out <= '0;
    end else if (capture_c) begin
      count_out <= popcount(in_vec);
    end
  end
`endif

endmodule
